// File: rtl/ram_pkg.sv
// Shared types and helpers for the single-port clearable RAM.
package ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } ram_state_e;

  // Address width for a given depth; never narrower than one bit.
  function automatic int ram_aw(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/ram_sp_array.sv
// Bare storage array: one synchronous write port, one registered read port.
// The read register clears on Rst and can be loaded with zero for
// out-of-range reads, so the top never needs a separate output stage.
module ram_sp_array #(
  parameter int WW    = 10,
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [WW-1:0] wr_data,
  input  logic          rd_en,
  input  logic          rd_ok,
  input  logic [AW-1:0] rd_addr,
  output logic [WW-1:0] rd_data
);

  logic [WW-1:0] mem [DEPTH];

  // Write port: no reset, contents are initialised by the clear sweep.
  always_ff @(posedge Clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read register: holds between reads, zero for out-of-range addresses.
  always_ff @(posedge Clk) begin
    if (Rst)        rd_data <= '0;
    else if (rd_en) rd_data <= rd_ok ? mem[rd_addr] : '0;
  end

endmodule

// File: rtl/ram_sp_clr.sv
// Parametrised single-port RAM with a post-reset clear sweep.
// Optional feature: define RAM_PARITY_EN to store an even-parity bit per
// word and flag corrupted words on read through ParErr.
//
// state | meaning
// CLEAR | sweep writing INIT_VAL to every word, requests ignored, Busy=1
// IDLE  | normal read/write access
module ram_sp_clr
  import ram_pkg::*;
#(
  parameter int            DW       = 10,
  parameter int            DEPTH    = 256,
  parameter int            AW       = ram_aw(DEPTH),
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          En,
  input  logic          We,
  input  logic [AW-1:0] Addr,
  input  logic [DW-1:0] Din,
  output logic [DW-1:0] Dout,
  output logic          RdValid,
  output logic          Busy,
  output logic          ParErr
);

`ifdef RAM_PARITY_EN
  localparam int WW = DW + 1;
`else
  localparam int WW = DW;
`endif
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  ram_state_e    state_q, state_d;
  logic [AW-1:0] clr_addr_q;
  logic          in_range;
  logic          user_wr;
  logic          user_rd;
  logic          arr_we;
  logic [AW-1:0] arr_waddr;
  logic [WW-1:0] arr_wdata;
  logic [WW-1:0] arr_rdata;
  logic [WW-1:0] init_word;
  logic [WW-1:0] user_word;

  // State register; Rst always restarts the sweep.
  always_ff @(posedge Clk) begin
    if (Rst) state_q <= CLEAR;
    else     state_q <= state_d;
  end

  // Next state: leave CLEAR once the last word has been written.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR:   if (clr_addr_q == LAST_ADDR) state_d = IDLE;
      IDLE:    state_d = IDLE;
      default: state_d = CLEAR;
    endcase
  end

  // Sweep address counter, parked at zero outside the sweep.
  always_ff @(posedge Clk) begin
    if (Rst)
      clr_addr_q <= '0;
    else if (state_q == CLEAR)
      clr_addr_q <= (clr_addr_q == LAST_ADDR) ? '0 : clr_addr_q + 1'b1;
  end

  assign Busy     = (state_q == CLEAR);
  assign in_range = (int'(Addr) < DEPTH);
  assign user_wr  = !Rst && (state_q == IDLE) && En &&  We && in_range;
  assign user_rd  = !Rst && (state_q == IDLE) && En && !We;

`ifdef RAM_PARITY_EN
  assign init_word = {^INIT_VAL, INIT_VAL};
  assign user_word = {^Din, Din};
`else
  assign init_word = INIT_VAL;
  assign user_word = Din;
`endif

  // Sweep owns the write port while busy; user writes only in IDLE.
  always_comb begin
    arr_we    = 1'b0;
    arr_waddr = Addr;
    arr_wdata = user_word;
    if (!Rst && state_q == CLEAR) begin
      arr_we    = 1'b1;
      arr_waddr = clr_addr_q;
      arr_wdata = init_word;
    end else if (user_wr) begin
      arr_we = 1'b1;
    end
  end

  ram_sp_array #(
    .WW   (WW),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_array (
    .Clk    (Clk),
    .Rst    (Rst),
    .wr_en  (arr_we),
    .wr_addr(arr_waddr),
    .wr_data(arr_wdata),
    .rd_en  (user_rd),
    .rd_ok  (in_range),
    .rd_addr(Addr),
    .rd_data(arr_rdata)
  );

  // Read strobe: one pulse per accepted read, aligned with the new Dout.
  always_ff @(posedge Clk) begin
    if (Rst) RdValid <= 1'b0;
    else     RdValid <= user_rd;
  end

  assign Dout = arr_rdata[DW-1:0];

`ifdef RAM_PARITY_EN
  // Out-of-range reads load an all-zero word, which has even parity.
  assign ParErr = RdValid && (^arr_rdata);
`else
  assign ParErr = 1'b0;
`endif

endmodule
